// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM state encoding and default sizing.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  localparam int unsigned SPI_DATA_WIDTH  = 16;
  localparam int unsigned SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage input synchronizer with rising/falling edge detect on the synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, oversampled on clk, with tx holding register and rx strobe.
// Optional: SPI_SLAVE_MISO_TRISTATE_EN releases miso while raw ss is high.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH   = SPI_DATA_WIDTH,
  parameter int unsigned             SYNC_STAGES  = SPI_SYNC_STAGES,
  parameter logic [DATA_WIDTH-1:0]   DEFAULT_FILL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  new_data,
  output logic                  busy,
  output logic                  underrun,
  output logic                  frame_err
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic ss_s, ss_rise, ss_fall;
  logic sck_s, sck_rise, sck_fall;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .d(ss), .level(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .d(sck), .level(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d(mosi), .level(mosi_s), .rise(), .fall()
  );

  spi_state_t            state, state_n;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift, hold_data;
  logic                  hold_full;
  logic                  load, rx_step, tx_step, word_done, abort, ferr;
  logic [DATA_WIDTH-1:0] rx_next;
  logic                  miso_int;

  assign rx_next = {rx_shift[DATA_WIDTH-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // ss rising edge wins over any coincident sck edge; a falling sck with the
  // counter at 0 inside a frame is the end of a word and reloads like a frame start.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    rx_step   = 1'b0;
    tx_step   = 1'b0;
    word_done = 1'b0;
    abort     = 1'b0;
    ferr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss_fall) begin
          state_n = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_n = IDLE;
          abort   = 1'b1;
          ferr    = (bit_cnt != '0);
        end else if (sck_rise) begin
          rx_step   = 1'b1;
          word_done = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
        end else if (sck_fall) begin
          if (bit_cnt == '0) load    = 1'b1;
          else               tx_step = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      rx_data   <= '0;
      new_data  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      new_data  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= ferr;

      if (load) begin
        if (hold_full) begin
          tx_shift  <= hold_data;
          hold_full <= 1'b0;
        end else begin
          tx_shift <= DEFAULT_FILL;
          underrun <= 1'b1;
        end
      end else if (tx_step) begin
        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end

      // Only accepted while empty, so it never collides with the load clearing hold_full.
      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      if (abort || (load && state == IDLE)) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (rx_step) begin
        rx_shift <= rx_next;
        if (word_done) begin
          bit_cnt  <= '0;
          rx_data  <= rx_next;
          new_data <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign tx_ready = ~hold_full;
  assign busy     = (state == SHIFT);
  assign miso_int = (state == SHIFT) ? tx_shift[DATA_WIDTH-1] : 1'b0;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = ss ? 1'bz : miso_int;
`else
  assign miso = miso_int;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bench-side SPI master (4 clk per sck phase) plus scoreboard.
module tb_spi_slave;

  logic        clk = 1'b0;
  logic        rst, ss, sck, mosi, tx_valid;
  logic [15:0] tx_data;
  wire         miso, tx_ready, new_data, busy, underrun, frame_err;
  wire  [15:0] rx_data;

  always #5 clk = ~clk;

  spi_slave #(
    .DATA_WIDTH  (16),
    .SYNC_STAGES (2),
    .DEFAULT_FILL(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .new_data(new_data), .busy(busy),
    .underrun(underrun), .frame_err(frame_err)
  );

  int unsigned n_vec = 0, n_miss = 0;
  int unsigned exp_under = 0, act_under = 0, exp_ferr = 0, act_ferr = 0;
  logic [15:0] exp_rx_q[$];
  logic [15:0] exp_miso_q[$];
  logic        model_full = 1'b0;
  logic [15:0] model_hold = '0;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every new_data pulse must match the oldest word sent in full.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (new_data === 1'b1) begin
        if (exp_rx_q.size() == 0) check_vec("rx_q_nonempty", 32'(exp_rx_q.size()), 32'd1);
        else                      check_vec("rx_data", {16'h0, rx_data}, {16'h0, exp_rx_q.pop_front()});
      end
      if (underrun === 1'b1)  act_under++;
      if (frame_err === 1'b1) act_ferr++;
    end
  end

  // Word the responder should load at a frame start or word boundary.
  task automatic model_load();
    if (model_full) begin
      exp_miso_q.push_back(model_hold);
      model_full = 1'b0;
    end else begin
      exp_miso_q.push_back(16'h0000);
      exp_under++;
    end
  endtask

  task automatic tx_write(input logic [15:0] d);
    check_vec("tx_ready_before_write", {31'h0, tx_ready}, {31'h0, ~model_full});
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    model_full = 1'b1;
    model_hold = d;
    @(negedge clk);
  endtask

  task automatic master_word(input logic [15:0] w, input int unsigned nbits,
                             input logic wr_en, input logic [15:0] wr_d,
                             output logic [15:0] rd);
    rd = '0;
    for (int i = 0; i < int'(nbits); i++) begin
      mosi = w[15-i];
      repeat (4) @(negedge clk);
      rd  = {rd[14:0], miso};
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
      if (wr_en && i == 8) tx_write(wr_d);
    end
  endtask

  task automatic frame(input int unsigned nw, input logic [15:0] w0, input logic [15:0] w1,
                       input logic wr_en, input logic [15:0] wr_d, input int unsigned last_bits);
    logic [15:0] rd, w, em;
    int unsigned bits;
    ss = 1'b0;
    model_load();
    repeat (4) @(negedge clk);
    check_vec("busy_in_frame", {31'h0, busy}, 32'd1);
    check_vec("miso_first_bit", {31'h0, miso}, {31'h0, exp_miso_q[0][15]});
    for (int k = 0; k < int'(nw); k++) begin
      w    = (k == 0) ? w0 : w1;
      bits = (k == int'(nw) - 1) ? last_bits : 16;
      if (bits == 16) exp_rx_q.push_back(w);
      master_word(w, bits, wr_en && (k == 0), wr_d, rd);
      if (bits == 16) begin
        em = exp_miso_q.pop_front();
        check_vec("miso_word", {16'h0, rd}, {16'h0, em});
        model_load();
      end else begin
        exp_ferr++;
      end
    end
    repeat (4) @(negedge clk);
    ss = 1'b1;
    exp_miso_q.delete();
    repeat (8) @(negedge clk);
    check_vec("busy_after_frame", {31'h0, busy}, 32'd0);
    check_vec("underrun_count", act_under, exp_under);
    check_vec("frame_err_count", act_ferr, exp_ferr);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    check_vec("miso_idle", {31'h0, miso}, {31'h0, 1'bz});
`else
    check_vec("miso_idle", {31'h0, miso}, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check_vec("reset_tx_ready", {31'h0, tx_ready}, 32'd1);
    check_vec("reset_busy", {31'h0, busy}, 32'd0);
    check_vec("reset_rx_data", {16'h0, rx_data}, 32'd0);
    check_vec("reset_new_data", {31'h0, new_data}, 32'd0);
    check_vec("reset_underrun", {31'h0, underrun}, 32'd0);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    check_vec("reset_miso", {31'h0, miso}, {31'h0, 1'bz});
`else
    check_vec("reset_miso", {31'h0, miso}, 32'd0);
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);

    tx_write(16'hA5C3);
    check_vec("tx_ready_full", {31'h0, tx_ready}, 32'd0);
    frame(1, 16'h3C5A, 16'h0, 1'b0, 16'h0, 16);
    check_vec("tx_ready_after_load", {31'h0, tx_ready}, 32'd1);

    frame(1, 16'h5AA5, 16'h0, 1'b0, 16'h0, 16);

    tx_write(16'h0F0F);
    frame(2, 16'h1234, 16'hABCD, 1'b1, 16'hF0F0, 16);

    tx_write(16'h1111);
    frame(1, 16'hFFFF, 16'h0, 1'b0, 16'h0, 7);
    check_vec("rx_kept_after_abort", {16'h0, rx_data}, 32'h0000ABCD);
    frame(1, 16'h6E21, 16'h0, 1'b0, 16'h0, 16);

    repeat (4) @(negedge clk);
    check_vec("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI peripheral (responder) for the 16-bit SPI master in this design.
- SPI mode 0, MSB first, fixed 16-bit words.
- Synchronous to the system clk; oversamples the master's sck, ss and mosi.
- Fabric-side interface is a word handshake: a transmit holding register plus a receive-word strobe. Used for FPGA-to-FPGA links and for loopback benches of the master.

Parameters:
- DATA_WIDTH, 16: word length in bits. The master is fixed at 16.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers (minimum 2).
- DEFAULT_FILL, 16'h0000: word shifted out on miso when no tx word is pending at frame start.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- ss  input  1  slave select from master, active low, asynchronous to clk.
- sck  input  1  serial clock from master, idle low, asynchronous to clk.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master.
- tx_data  input  DATA_WIDTH  word to send in the next frame.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding register empty; a transfer occurs when tx_valid and tx_ready are both high.
- rx_data  output  DATA_WIDTH  last complete received word.
- new_data  output  1  one-clk pulse; rx_data was just updated.
- busy  output  1  frame in progress (synchronized ss low).
- underrun  output  1  one-clk pulse; a frame started with no pending tx word.
- frame_err  output  1  one-clk pulse; ss rose before DATA_WIDTH bits were received.

Behaviour:
- Reset (rst low at a clk edge):
  - state IDLE, all counters 0, holding register empty.
  - Outputs: tx_ready=1, rx_data=0, new_data=0, busy=0, underrun=0, frame_err=0, miso=0.
  - Synchronizer flops reset to the idle levels: ss=1, sck=0.
- Input path: ss, sck and mosi each pass through a SYNC_STAGES flop chain. Edges are detected by comparing the last synchronized stage with one extra registered copy.
- Detection latency is SYNC_STAGES+1 clk. Master sck high and low phases must each be at least 4 clk, i.e. master CLK_DIV >= 3. CLK_DIV=2 is not supported.
- State machine:
  - IDLE -> SHIFT on ss falling edge.
    - Load the shift register from the holding register if it is full, and mark the holding register empty.
    - Otherwise load DEFAULT_FILL and pulse underrun.
    - Bit counter = 0. miso = shift register MSB on the next clk.
  - SHIFT:
    - On sck rising edge: capture synchronized mosi into rx shift register bit 0 (shift left) and increment the bit counter.
    - On sck falling edge: shift the tx register left, so miso presents the next bit.
    - After the DATA_WIDTH-th rising edge: rx_data <= received word and new_data pulses on the following clk. The bit counter wraps to 0.
    - The falling edge after the last bit loads the next word exactly as at frame start, so back-to-back words work without ss deasserting.
  - SHIFT -> IDLE on ss rising edge.
    - If the bit counter != 0: pulse frame_err, discard partial rx bits, leave rx_data unchanged, no new_data.
    - The tx word already loaded is consumed, not restored.
- tx handshake:
  - tx_ready = holding register empty.
  - A write while tx_ready=0 is ignored.
  - A write in the same clk as a frame-start load: the load takes the old word and the write is blocked, because tx_ready was 0.
  - If the holding register is empty at frame start and tx_valid is high in that same clk, the write is accepted, but DEFAULT_FILL is still sent and underrun pulses.
- Simultaneous ss rising edge and sck edge: ss takes priority; the sck edge is ignored.
- Reset mid-frame returns to IDLE immediately with no pulses; the master's frame is corrupted.

Optional Feature:
- Macro SPI_SLAVE_MISO_TRISTATE_EN.
- Defined: miso = 1'bz whenever raw (unsynchronized) ss is high, so multiple slaves can share the line.
- Not defined: miso is always driven; it is 0 while IDLE and the shift register MSB otherwise.

Decomposition:
- Package spi_pkg: state encoding (IDLE, SHIFT), default DATA_WIDTH constant, default SYNC_STAGES.
- Sub-module spi_sync_edge: parameterized synchronizer with rise/fall detect outputs. Instantiated for ss and sck; mosi uses its level output only.

Test Plan (master CLK_DIV=3 driven by the bench):
- Reset with rst=0 for 3 clk -> tx_ready=1, miso=0, busy=0, rx_data=16'h0000.
- tx write 16'hA5C3, master sends 16'h3C5A -> master reads 16'hA5C3; rx_data=16'h3C5A with a single new_data pulse; tx_ready returns to 1 at frame start.
- Frame with no tx write and DEFAULT_FILL=16'h0000 -> underrun pulses once, master reads 16'h0000, rx still correct.
- Two back-to-back words 16'h1234, 16'hABCD without ss deassert, tx 16'h0F0F then 16'hF0F0 written between words -> two new_data pulses, master reads 16'h0F0F, 16'hF0F0.
- ss raised after 7 bits -> frame_err pulses once, no new_data, rx_data keeps its prior value; the next full frame is received correctly.
- With SPI_SLAVE_MISO_TRISTATE_EN defined -> miso=z while ss=1 and driven within 1 clk... of the synchronized frame start. Without the macro -> miso=0 while ss=1.
